// File: rtl/j_slatch_bank.sv
// j_slatch_bank: CH-channel, W-bit double-buffered latch bank clocked on
// sys_clk, written on rising edges of the logical clock clk.
// Ports: sys_clk, reset (async, active high), clk, en[CH], d[CH*W],
//        commit, q[CH*W], pend[CH], ovf[CH], pend_cnt, busy.
// Optional: define J_SLATCH_BANK_CLR_EN to add clr[CH], which loads
//           RESET_VAL into a channel on an edge, with priority over en.
module j_slatch_bank #(
    parameter int              CH          = 4,
    parameter int              W           = 8,
    parameter bit              AUTO_COMMIT = 1'b0,
    parameter logic [W-1:0]    RESET_VAL   = '0
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic                      clk,
    input  logic [CH-1:0]             en,
    input  logic [CH*W-1:0]           d,
    input  logic                      commit,
`ifdef J_SLATCH_BANK_CLR_EN
    input  logic [CH-1:0]             clr,
`endif
    output logic [CH*W-1:0]           q,
    output logic [CH-1:0]             pend,
    output logic [CH-1:0]             ovf,
    output logic [$clog2(CH+1)-1:0]   pend_cnt,
    output logic                      busy
);

    localparam int CW = $clog2(CH+1);

    logic            clk_d;
    logic            edge_w;
    logic [W-1:0]    stage [CH];
    logic [CH-1:0]   clr_w;
    logic [CH-1:0]   wr;
    logic [W-1:0]    wdat [CH];
    logic [CH-1:0]   pend_nxt;
    logic [CH-1:0]   ovf_nxt;
    logic [CW-1:0]   cnt_nxt;

`ifdef J_SLATCH_BANK_CLR_EN
    assign clr_w = clr;
`else
    assign clr_w = '0;
`endif

    // clk_d resets to 1 so a clk held high across reset is not an edge.
    assign edge_w = clk & ~clk_d;
    assign busy   = |pend;

    always_comb begin
        pend_nxt = pend;
        ovf_nxt  = ovf;
        cnt_nxt  = '0;
        for (int i = 0; i < CH; i++) begin
            wr[i]   = edge_w & (en[i] | clr_w[i]);
            wdat[i] = clr_w[i] ? RESET_VAL : d[i*W +: W];
        end
        if (!AUTO_COMMIT) begin
            if (commit) begin
                pend_nxt = '0;
                ovf_nxt  = '0;
            end
            // A write beats the commit clear for pend; ovf compares against
            // the pre-commit pend, which is being committed, so it stays 0.
            for (int i = 0; i < CH; i++) begin
                if (wr[i]) begin
                    pend_nxt[i] = 1'b1;
                    ovf_nxt[i]  = ~commit & (ovf[i] | pend[i]);
                end
            end
        end
        for (int i = 0; i < CH; i++) begin
            cnt_nxt = cnt_nxt + CW'(pend_nxt[i]);
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            clk_d    <= 1'b1;
            q        <= {CH{RESET_VAL}};
            pend     <= '0;
            ovf      <= '0;
            pend_cnt <= '0;
            for (int i = 0; i < CH; i++) begin
                stage[i] <= RESET_VAL;
            end
        end else begin
            clk_d    <= clk;
            pend     <= pend_nxt;
            ovf      <= ovf_nxt;
            pend_cnt <= cnt_nxt;
            for (int i = 0; i < CH; i++) begin
                if (AUTO_COMMIT) begin
                    if (wr[i]) begin
                        q[i*W +: W] <= wdat[i];
                    end
                end else begin
                    if (commit && pend[i]) begin
                        q[i*W +: W] <= stage[i];
                    end
                    if (wr[i]) begin
                        stage[i] <= wdat[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_j_slatch_bank.sv
// tb_j_slatch_bank: directed checks of j_slatch_bank in staged mode and
// in AUTO_COMMIT mode, with hand-computed expected values.
module tb_j_slatch_bank;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        clk;
    logic [3:0]  en;
    logic [31:0] d;
    logic        commit;
`ifdef J_SLATCH_BANK_CLR_EN
    logic [3:0]  clr = '0;
`endif

    logic [31:0] q_a, q_b;
    logic [3:0]  pend_a, pend_b, ovf_a, ovf_b;
    logic [2:0]  cnt_a, cnt_b;
    logic        busy_a, busy_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    j_slatch_bank #(.CH(4), .W(8), .AUTO_COMMIT(1'b0)) u_a (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clk     (clk),
        .en      (en),
        .d       (d),
        .commit  (commit),
`ifdef J_SLATCH_BANK_CLR_EN
        .clr     (clr),
`endif
        .q       (q_a),
        .pend    (pend_a),
        .ovf     (ovf_a),
        .pend_cnt(cnt_a),
        .busy    (busy_a)
    );

    j_slatch_bank #(.CH(4), .W(8), .AUTO_COMMIT(1'b1)) u_b (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clk     (clk),
        .en      (en),
        .d       (d),
        .commit  (commit),
`ifdef J_SLATCH_BANK_CLR_EN
        .clr     (clr),
`endif
        .q       (q_b),
        .pend    (pend_b),
        .ovf     (ovf_b),
        .pend_cnt(cnt_b),
        .busy    (busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse();
        clk = 1'b1;
        tick();
        clk = 1'b0;
        tick();
    endtask

    initial begin
        reset  = 1'b1;
        clk    = 1'b1;
        en     = '0;
        d      = '0;
        commit = 1'b0;
        tick();
        tick();
        chk("rst_q", q_a, 32'h0);
        chk("rst_pend", {28'h0, pend_a}, 32'h0);
        chk("rst_ovf", {28'h0, ovf_a}, 32'h0);
        chk("rst_cnt", {29'h0, cnt_a}, 32'h0);
        chk("rst_busy", {31'h0, busy_a}, 32'h0);

        // clk high through reset release: no write
        reset = 1'b0;
        en    = 4'b1111;
        d     = 32'hFFFF_FFFF;
        repeat (5) tick();
        chk("hold_q", q_a, 32'h0);
        chk("hold_pend", {28'h0, pend_a}, 32'h0);
        chk("hold_qb", q_b, 32'h0);
        en  = '0;
        clk = 1'b0;
        tick();

        // basic staged write
        en  = 4'b0101;
        d   = 32'h4433_2211;
        clk = 1'b1;
        tick();
        chk("wr_pend", {28'h0, pend_a}, 32'h5);
        chk("wr_cnt", {29'h0, cnt_a}, 32'h2);
        chk("wr_q", q_a, 32'h0);
        chk("wr_busy", {31'h0, busy_a}, 32'h1);
        tick();
        tick();
        chk("long_hi_ovf", {28'h0, ovf_a}, 32'h0);
        chk("long_hi_pend", {28'h0, pend_a}, 32'h5);
        clk = 1'b0;
        en  = '0;
        tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("cm_q", q_a, 32'h0033_0011);
        chk("cm_pend", {28'h0, pend_a}, 32'h0);
        chk("cm_cnt", {29'h0, cnt_a}, 32'h0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("cm_noop_q", q_a, 32'h0033_0011);

        // overrun on channel 2
        en = 4'b0100;
        d  = 32'h00AA_0000;
        pulse();
        d  = 32'h00BB_0000;
        pulse();
        chk("ovf_ovf", {28'h0, ovf_a}, 32'h4);
        chk("ovf_pend", {28'h0, pend_a}, 32'h4);
        en     = '0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("ovf_q", q_a, 32'h00BB_0011);
        chk("ovf_clr", {28'h0, ovf_a}, 32'h0);

        // edge and commit in the same cycle
        en = 4'b0001;
        d  = 32'h0000_0099;
        pulse();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("pre_q", q_a, 32'h00BB_0099);
        d = 32'h0000_0011;
        pulse();
        d      = 32'h0000_005A;
        clk    = 1'b1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        clk    = 1'b0;
        en     = '0;
        chk("same_q", q_a, 32'h00BB_0011);
        chk("same_pend", {28'h0, pend_a}, 32'h1);
        chk("same_ovf", {28'h0, ovf_a}, 32'h0);
        chk("same_cnt", {29'h0, cnt_a}, 32'h1);
        tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("same_stage", q_a, 32'h00BB_005A);

        // asynchronous reset while all channels pending
        en = 4'b1111;
        d  = 32'h0102_0304;
        pulse();
        pulse();
        en = '0;
        chk("full_pend", {28'h0, pend_a}, 32'hF);
        chk("full_cnt", {29'h0, cnt_a}, 32'h4);
        reset = 1'b1;
        #1;
        chk("ar_q", q_a, 32'h0);
        chk("ar_pend", {28'h0, pend_a}, 32'h0);
        chk("ar_ovf", {28'h0, ovf_a}, 32'h0);
        chk("ar_cnt", {29'h0, cnt_a}, 32'h0);
        #1;
        reset = 1'b0;
        tick();
        tick();
        en = 4'b0010;
        d  = 32'h0000_AB00;
        pulse();
        en = '0;
        chk("post_pend", {28'h0, pend_a}, 32'h2);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("post_q", q_a, 32'h0000_AB00);

        // AUTO_COMMIT instance
        reset = 1'b1;
        #1;
        reset = 1'b0;
        tick();
        tick();
        chk("ac_rst_q", q_b, 32'h0);
        en  = 4'b1000;
        d   = 32'hC300_0000;
        clk = 1'b1;
        #2;
        chk("ac_lat_q", q_b, 32'h0);
        tick();
        chk("ac_q", q_b, 32'hC300_0000);
        chk("ac_pend", {28'h0, pend_b}, 32'h0);
        chk("ac_cnt", {29'h0, cnt_b}, 32'h0);
        chk("ac_busy", {31'h0, busy_b}, 32'h0);
        clk    = 1'b0;
        en     = '0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("ac_cm_q", q_b, 32'hC300_0000);
        chk("ac_cm_pend", {28'h0, pend_b}, 32'h0);
        chk("ac_ovf", {28'h0, ovf_b}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/j_slatch_bank.md
Name: j_slatch_bank

Overview:
- Parametrised multi-channel successor to the single-bit enabled latch cell.
- Holds CH channels of W bits each. Each channel has its own enable, sampled on rising edges of the logical clock input clk, which is detected in the sys_clk domain.
- Double-buffered: writes land in a staging register and reach q only on a commit strobe. Pending, overrun and count status are also provided.
- Used by JERRY register files that must update several fields atomically.

Parameters:
- CH, 4, number of channels (1..16).
- W, 8, bits per channel (1..32).
- AUTO_COMMIT, 0, when 1, staging is bypassed and writes update q directly on the detected clk edge.
- RESET_VAL, 0, W-bit value loaded into every stage and q slice on reset.

Ports:
- sys_clk  in  1  system clock; all state is clocked on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- clk  in  1  logical latch clock; a rising edge is detected against sys_clk.
- en  in  CH  per-channel write enable, sampled on a detected clk edge.
- d  in  CH*W  write data; channel i occupies d[i*W +: W].
- commit  in  1  transfers pending stage slices to q.
- q  out  CH*W  active outputs; channel i occupies q[i*W +: W].
- pend  out  CH  channel i staged but not yet committed.
- ovf  out  CH  sticky: channel i was rewritten while already pending.
- pend_cnt  out  $clog2(CH+1)  registered popcount of pend.
- busy  out  1  equals |pend.

Behaviour:
- Reset (asynchronous):
  - q and stage = RESET_VAL in every channel.
  - pend = 0, ovf = 0, pend_cnt = 0, busy = 0.
  - clk_d (previous-clk register) = 1, so clk held high through reset gives no spurious edge.
- Edge detect: edge = clk & ~clk_d, with clk_d <= clk every sys_clk cycle. One edge yields exactly one write cycle, whatever the clk high time.
- Write (edge=1, AUTO_COMMIT=0), for each i with en[i]=1:
  - stage[i] <= d slice i.
  - pend[i] <= 1.
  - ovf[i] <= 1 if pend[i] was already 1.
  - Channels with en[i]=0 are unchanged.
- Commit (commit=1, AUTO_COMMIT=0):
  - q[i] <= stage[i] for every i with pend[i]=1; pend cleared; ovf cleared.
  - q is visible one sys_clk cycle after commit is sampled.
  - Commit with pend=0 is a no-op.
- Edge and commit in the same cycle:
  - q takes the old stage contents.
  - The new write lands in stage and its pend bit ends at 1; write wins over commit clear.
  - ovf for that channel ends at 0, because commit clears it and the pend it was compared against is the pre-commit value being committed.
- AUTO_COMMIT=1:
  - On edge, q[i] <= d slice i for each en[i]=1, one-cycle latency.
  - commit is ignored; pend, ovf, pend_cnt and busy stay 0.
  - With CH=1, W=1 this equals the legacy cell.
- pend_cnt: registered, updated in the same cycle as pend; saturation is impossible by width.
- busy: combinational OR of pend.
- Reset mid-operation: all staged data and pending state are discarded immediately; q returns to RESET_VAL.

Optional Feature:
- Macro: J_SLATCH_BANK_CLR_EN.
- Defined:
  - Adds port clr (in, CH).
  - On a detected edge, clr[i]=1 loads stage[i] (or q[i] when AUTO_COMMIT=1) with RESET_VAL and sets pend and ovf exactly as a write does.
  - clr[i] takes priority over en[i].
- Not defined: the port is absent and the only channel update source is en/d.

Test Plan:
- Reset with clk=1, release reset, hold clk=1 for 5 cycles -> no write occurs, q=0, pend=0.
- CH=4, W=8: d=0x44332211, en=0b0101, clk rising, then commit -> before commit q=0 and pend=0b0101, pend_cnt=2; one cycle after commit q=0x00330011, pend=0.
- Two clk edges to channel 2 (d slice 0xAA, then 0xBB) before commit -> ovf=0b0100, q slice 2 = 0xBB after commit, ovf cleared.
- clk edge writing 0x5A to channel 0 in the same cycle as commit (stage[0]=0x11 pending) -> q slice 0 = 0x11, stage slice 0 = 0x5A, pend[0]=1, ovf[0]=0.
- AUTO_COMMIT=1: en=0b1000, d slice 3 = 0xC3, clk rising -> q slice 3 = 0xC3 one sys_clk later; pend=0, commit has no effect.
- Assert reset while pend=0b1111 -> q, pend, ovf and pend_cnt are 0 in the same cycle (asynchronous); the first clk edge after release writes normally.
